// File: rtl/ctrl_word_executor.sv
// rtl/ctrl_word_executor.sv - control-word executor: register file + ALU behind cmd/rsp valid/ready handshakes
// One command in flight: IDLE accepts, EXEC computes and writes back, RESP holds the result until taken.
module ctrl_word_executor #(
  parameter int DATA_W = 8,
  parameter int NREG   = 4,
  localparam int IDX_W = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [3:0]        cmd_op,
  input  logic [IDX_W-1:0]  cmd_dst,
  input  logic [IDX_W-1:0]  cmd_src,
  input  logic [DATA_W-1:0] cmd_imm,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic [2:0]        rsp_flags
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  localparam logic [DATA_W:0] ONE_X = {{DATA_W{1'b0}}, 1'b1};

  state_t            state;
  logic              armed;
  logic              carry_q;
  logic [3:0]        op_q;
  logic [IDX_W-1:0]  dst_q;
  logic [IDX_W-1:0]  src_q;
  logic [DATA_W-1:0] imm_q;
  logic [DATA_W-1:0] regs [NREG];

  logic [DATA_W-1:0] opa, opb, res;
  logic [DATA_W:0]   ext;
  logic              c_new, c_upd, wr, err;

  // armed keeps cmd_ready low while reset is held and for the first edge after release
  assign cmd_ready = armed && ena && (state == IDLE);

  always_comb begin
    opa   = regs[dst_q];
    opb   = regs[src_q];
    ext   = '0;
    res   = '0;
    c_new = carry_q;
    c_upd = 1'b0;
    wr    = 1'b1;
    err   = 1'b0;
    case (op_q)
      4'd0:  wr = 1'b0;
      4'd1:  res = imm_q;
      4'd2:  res = opb;
      4'd3: begin
        ext = {1'b0, opa} + {1'b0, opb};
        {c_new, res} = ext;
        c_upd = 1'b1;
      end
      4'd4: begin
        // the extra top bit of the widened difference is the borrow
        ext = {1'b0, opa} - {1'b0, opb};
        {c_new, res} = ext;
        c_upd = 1'b1;
      end
      4'd5:  res = opa & opb;
      4'd6:  res = opa | opb;
      4'd7:  res = opa ^ opb;
      4'd8: begin
        c_new = opa[DATA_W-1];
        res   = {opa[DATA_W-2:0], 1'b0};
        c_upd = 1'b1;
      end
      4'd9: begin
        c_new = opa[0];
        res   = {1'b0, opa[DATA_W-1:1]};
        c_upd = 1'b1;
      end
      4'd10: begin
        ext = {1'b0, opa} + ONE_X;
        {c_new, res} = ext;
        c_upd = 1'b1;
      end
      4'd11: begin
        ext = {1'b0, opa} - ONE_X;
        {c_new, res} = ext;
        c_upd = 1'b1;
      end
      4'd12: begin
        wr  = 1'b0;
        res = opb;
      end
      4'd13: begin
        ext = {1'b0, opa} + {1'b0, imm_q};
        {c_new, res} = ext;
        c_upd = 1'b1;
      end
      default: begin
        wr  = 1'b0;
        err = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      armed     <= 1'b0;
      carry_q   <= 1'b0;
      op_q      <= '0;
      dst_q     <= '0;
      src_q     <= '0;
      imm_q     <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_flags <= '0;
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else begin
      armed <= 1'b1;
      case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            op_q  <= cmd_op;
            dst_q <= cmd_dst;
            src_q <= cmd_src;
            imm_q <= cmd_imm;
            state <= EXEC;
          end
        end
        EXEC: begin
          if (wr) regs[dst_q] <= res;
          if (c_upd) carry_q <= c_new;
          rsp_data  <= res;
          rsp_flags <= {err, c_upd ? c_new : carry_q, !err && (res == '0)};
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
